// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MD   = 2'd1,
    ST_MEMW = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  localparam int MULT_LAT_DEF    = 5;
  localparam int DIV_LAT_DEF     = 10;
  localparam int MEM_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF       = 8;

  typedef struct packed {
    logic en;
    logic clr;
  } stg_ctl_t;

  localparam stg_ctl_t STG_RUN    = '{en: 1'b1, clr: 1'b0};
  localparam stg_ctl_t STG_HOLD   = '{en: 1'b0, clr: 1'b0};
  localparam stg_ctl_t STG_BUBBLE = '{en: 1'b1, clr: 1'b1};
endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the D/E/M stages and the per-stage en/clr controls.
interface pipe_ctrl_if;
  logic [4:0] RsD, RtD, RegAddrE;
  logic       MemtoRegE, RegWriteE, BranchD, MdUseD, MdStartE, MdDivE;
  logic       MemReqM, MemReadyM;
  logic       EnF, EnD, ClrD, EnE, ClrE, EnM, ClrM, EnW, ClrW;
  logic       MdBusy, MemErr;
  logic [1:0] StateOut;

  modport master (
    output RsD, RtD, RegAddrE, MemtoRegE, RegWriteE, BranchD, MdUseD,
           MdStartE, MdDivE, MemReqM, MemReadyM,
    input  EnF, EnD, ClrD, EnE, ClrE, EnM, ClrM, EnW, ClrW, MdBusy, MemErr,
           StateOut
  );

  modport slave (
    input  RsD, RtD, RegAddrE, MemtoRegE, RegWriteE, BranchD, MdUseD,
           MdStartE, MdDivE, MemReqM, MemReadyM,
    output EnF, EnD, ClrD, EnE, ClrE, EnM, ClrM, EnW, ClrW, MdBusy, MemErr,
           StateOut
  );
endinterface

// File: rtl/pipe_ctrl_md_timer.sv
// MDU occupancy down-counter: busy from the cycle after start until the count drains.
module md_timer #(
  parameter int MULT_LAT = pipe_ctrl_pkg::MULT_LAT_DEF,
  parameter int DIV_LAT  = pipe_ctrl_pkg::DIV_LAT_DEF,
  parameter int CNT_W    = pipe_ctrl_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  output logic             busy,
  output logic [CNT_W-1:0] cnt
);
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  // A start while busy restarts the count from the new op's latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
    end else if (busy_q) begin
      if (cnt_q == '0) busy_q <= 1'b0;
      else             cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign busy = busy_q;
  assign cnt  = cnt_q;
endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: load-use, MDU occupancy and data-memory wait with watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_LAT    = MULT_LAT_DEF,
  parameter int DIV_LAT     = DIV_LAT_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  pipe_ctrl_if.slave bus
);
  state_e           state_q;
  logic [CNT_W-1:0] wdcnt_q;
  logic             err_q;
  logic             md_busy, md_busy_d, accept;
  logic [CNT_W-1:0] md_cnt;
  logic             loaduse, mdstall, memwait;
  stg_ctl_t         f, d, e, m, w;

  assign loaduse = bus.MemtoRegE & bus.RegWriteE & (bus.RegAddrE != 5'd0) &
                   ((bus.RegAddrE == bus.RsD) | (bus.RegAddrE == bus.RtD));
  assign mdstall = md_busy & bus.MdUseD;
  assign memwait = bus.MemReqM & ~bus.MemReadyM & ~err_q;

  // A branch that coincides with a stall is left alone; it re-resolves next cycle.
  always_comb begin
    f = STG_RUN; d = STG_RUN; e = STG_RUN; m = STG_RUN; w = STG_RUN;
    if (!reset) begin
      if (memwait) begin
        f = STG_HOLD; d = STG_HOLD; e = STG_HOLD; m = STG_HOLD; w = STG_BUBBLE;
      end else if (loaduse | mdstall) begin
        f = STG_HOLD; d = STG_HOLD; e = STG_BUBBLE;
      end else if (bus.BranchD) begin
        d = STG_BUBBLE;
      end
    end
  end

  assign accept    = bus.MdStartE & m.en & ~m.clr;
  assign md_busy_d = accept | (md_busy & (md_cnt != '0));

  md_timer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) u_md_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .is_div (bus.MdDivE),
    .busy   (md_busy),
    .cnt    (md_cnt)
  );

  // ERR is only left through reset; the MDU keeps running underneath every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      wdcnt_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q != ST_ERR) begin
      if (memwait) begin
        if (wdcnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_q <= ST_ERR;
          err_q   <= 1'b1;
        end else begin
          state_q <= ST_MEMW;
          wdcnt_q <= wdcnt_q + 1'b1;
        end
      end else begin
        wdcnt_q <= '0;
        state_q <= md_busy_d ? ST_MD : ST_RUN;
      end
    end
  end

  assign bus.EnF      = f.en;
  assign bus.EnD      = d.en;
  assign bus.ClrD     = d.clr;
  assign bus.EnE      = e.en;
  assign bus.ClrE     = e.clr;
  assign bus.EnM      = m.en;
  assign bus.ClrM     = m.clr;
  assign bus.EnW      = w.en;
  assign bus.ClrW     = w.clr;
  assign bus.MdBusy   = md_busy;
  assign bus.MemErr   = err_q;
  assign bus.StateOut = state_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed hazard scenarios followed by random traffic against a cycle-count reference model.
module tb_pipe_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .MEM_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: busy cycles left in the MDU, consecutive not-ready count, error flag, debug state.
  int         md_left;
  int         wd;
  bit         err;
  logic [1:0] st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_memwait();
    return bus.MemReqM & ~bus.MemReadyM & ~err;
  endfunction

  function automatic bit m_stall();
    bit lu;
    lu = bus.MemtoRegE && bus.RegWriteE && bus.RegAddrE != 0 &&
         (bus.RegAddrE == bus.RsD || bus.RegAddrE == bus.RtD);
    return lu || (md_left > 0 && bus.MdUseD);
  endfunction

  // {EnF,EnD,ClrD,EnE,ClrE,EnM,ClrM,EnW,ClrW,MdBusy,MemErr,StateOut}
  function automatic logic [12:0] m_outs();
    logic [8:0] s;
    if (reset)              s = 9'b1_10_10_10_10;
    else if (m_memwait())   s = 9'b0_00_00_00_11;
    else if (m_stall())     s = 9'b0_00_11_10_10;
    else if (bus.BranchD)   s = 9'b1_11_10_10_10;
    else                    s = 9'b1_10_10_10_10;
    return {s, md_left > 0, err, st};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {bus.EnF, bus.EnD, bus.ClrD, bus.EnE, bus.ClrE, bus.EnM, bus.ClrM,
            bus.EnW, bus.ClrW, bus.MdBusy, bus.MemErr, bus.StateOut};
  endfunction

  task automatic settle(input string tag);
    #1;
    chk(tag, 32'(dut_outs()), 32'(m_outs()));
  endtask

  task automatic adv();
    bit mw, acc;
    mw  = m_memwait();
    acc = bus.MdStartE && !mw;
    @(posedge clk);
    if (reset) begin
      md_left = 0; wd = 0; err = 0; st = 2'd0;
    end else begin
      if (acc)              md_left = bus.MdDivE ? 10 : 5;
      else if (md_left > 0) md_left--;
      if (!err) begin
        if (mw) begin
          wd++;
          if (wd >= TO) begin err = 1; st = 2'd3; end
          else st = 2'd2;
        end else begin
          wd = 0;
          st = (md_left > 0) ? 2'd1 : 2'd0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    bus.RsD = 0; bus.RtD = 0; bus.RegAddrE = 0; bus.MemtoRegE = 0; bus.RegWriteE = 0;
    bus.BranchD = 0; bus.MdUseD = 0; bus.MdStartE = 0; bus.MdDivE = 0;
    bus.MemReqM = 0; bus.MemReadyM = 1;
  endtask

  initial begin
    md_left = 0; wd = 0; err = 0; st = 0;
    reset = 1'b1;
    idle();
    @(negedge clk);
    settle("rst0"); adv();
    settle("rst1"); adv();
    reset = 1'b0;
    settle("post_rst");
    chk("rst_state", 32'(bus.StateOut), 0);
    chk("rst_busy", 32'(bus.MdBusy), 0);
    chk("rst_err", 32'(bus.MemErr), 0);
    adv();

    // load-use on rs
    bus.RegAddrE = 8; bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.RsD = 8;
    settle("lu");
    chk("lu_enf_end_clre", 32'({bus.EnF, bus.EnD, bus.EnE, bus.ClrE}), 32'b0011);
    adv();
    bus.RegAddrE = 3;
    settle("lu_rel");
    chk("lu_rel_end", 32'(bus.EnD), 1);
    adv();

    // $0 destination never stalls
    bus.RegAddrE = 0; bus.RsD = 0;
    settle("lu_r0");
    chk("lu_r0_end", 32'(bus.EnD), 1);
    adv();
    idle();

    // divide occupancy with a dependent ID instruction
    bus.MdStartE = 1; bus.MdDivE = 1;
    settle("div_start"); adv();
    bus.MdStartE = 0; bus.MdUseD = 1;
    for (int i = 0; i < 10; i++) begin
      settle("div_run");
      chk("div_busy", 32'({bus.MdBusy, bus.EnD, bus.StateOut}), 32'b1_0_01);
      adv();
    end
    settle("div_rel");
    chk("div_rel", 32'({bus.MdBusy, bus.EnD}), 32'b01);
    adv();
    idle();

    // three memory wait cycles then ready
    bus.MemReqM = 1; bus.MemReadyM = 0;
    for (int i = 0; i < 3; i++) begin
      settle("mw");
      chk("mw_freeze", 32'({bus.EnM, bus.EnW, bus.ClrW}), 32'b011);
      adv();
    end
    chk("mw_state", 32'(bus.StateOut), 2);
    bus.MemReadyM = 1;
    settle("mw_ready"); adv();
    idle();
    settle("mw_done");
    chk("mw_done_state", 32'(bus.StateOut), 0);
    adv();

    // branch vs stall priority
    bus.BranchD = 1; bus.RegAddrE = 5; bus.MemtoRegE = 1; bus.RegWriteE = 1; bus.RtD = 5;
    settle("br_stall");
    chk("br_stall_clrd", 32'(bus.ClrD), 0);
    adv();
    bus.MemtoRegE = 0;
    settle("br_alone");
    chk("br_alone", 32'({bus.ClrD, bus.EnD}), 32'b11);
    adv();
    idle();

    // reset mid-multiply
    bus.MdStartE = 1; settle("mul_start"); adv();
    bus.MdStartE = 0; settle("mul_run"); adv();
    reset = 1; settle("mul_rst"); adv();
    reset = 0; settle("mul_after_rst");
    chk("mul_rst_busy", 32'(bus.MdBusy), 0);
    adv();

    // watchdog
    bus.MemReqM = 1; bus.MemReadyM = 0;
    for (int i = 0; i < TO; i++) begin settle("wd"); adv(); end
    settle("wd_err");
    chk("wd_err", 32'({bus.MemErr, bus.EnM, bus.StateOut}), 32'b1_1_11);
    adv();
    settle("wd_sticky"); adv();
    reset = 1; settle("wd_rst"); adv();
    reset = 0; settle("wd_clr");
    chk("wd_clr", 32'(bus.MemErr), 0);
    adv();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.RsD       = 5'($urandom_range(0, 3));
      bus.RtD       = 5'($urandom_range(0, 3));
      bus.RegAddrE  = 5'($urandom_range(0, 3));
      bus.MemtoRegE = ($urandom_range(0, 99) < 40);
      bus.RegWriteE = ($urandom_range(0, 99) < 70);
      bus.BranchD   = ($urandom_range(0, 99) < 20);
      bus.MdUseD    = ($urandom_range(0, 99) < 30);
      bus.MdStartE  = ($urandom_range(0, 99) < 10);
      bus.MdDivE    = 1'($urandom);
      bus.MemReqM   = ($urandom_range(0, 99) < 30);
      bus.MemReadyM = ($urandom_range(0, 99) < 55);
      reset         = ($urandom_range(0, 99) < 2);
      settle("rand");
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
